// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, micro-instruction
// field layout and datapath widths.
package alu_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int IMM_W      = 16;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 29;
  localparam int USE_IMM_BIT = 28;
  localparam int ZERO_A_BIT  = 27;
  localparam int WB_EN_BIT   = 26;
  localparam int RD_MSB      = 25;
  localparam int RD_LSB      = 21;
  localparam int RS_MSB      = 20;
  localparam int RS_LSB      = 16;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0]            alu_op;
    logic                  use_imm;
    logic                  zero_a;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [IMM_W-1:0]      imm;
  } instr_fields_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational field split of a micro-instruction word.
module alu_instr_decode
  import alu_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_word,
  output instr_fields_t      fields
);

  always_comb begin
    fields.alu_op  = instr_word[OP_MSB:OP_LSB];
    fields.use_imm = instr_word[USE_IMM_BIT];
    fields.zero_a  = instr_word[ZERO_A_BIT];
    fields.wb_en   = instr_word[WB_EN_BIT];
    fields.rd      = instr_word[RD_MSB:RD_LSB];
    fields.rs      = instr_word[RS_MSB:RS_LSB];
    fields.rt      = instr_word[IMM_LSB+REG_ADDR_W-1:IMM_LSB];
    fields.imm     = instr_word[IMM_MSB:IMM_LSB];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Issue-side sequencer for the ALU/register-file datapath: accepts one
// micro-instruction, walks DECODE/EXEC/WB, then returns a status response.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter bit          R0_READ_ONLY = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [INSTR_W-1:0]    cmd_instr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_result,
  output logic                  resp_ovf,
  output logic                  resp_zero,
  output logic [CNT_W-1:0]      retired,
  output logic [REG_ADDR_W-1:0] read_addr1,
  output logic [REG_ADDR_W-1:0] read_addr2,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W:0]       write_data,
  output logic                  reg_read,
  output logic                  reg_write,
  output logic [IMM_W-1:0]      instr,
  output logic                  ALUSrc1,
  output logic                  ALUSrc2,
  output logic [2:0]            ALUOp,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  ovf,
  input  logic                  zero
);

  state_t state, next_state;
  logic [INSTR_W-1:0] instr_q, instr_d;
  instr_fields_t      f;
  logic               accept;
  logic               resp_valid_q, reg_write_q;

  logic [REG_ADDR_W-1:0] ra1_d, ra2_d, wa_d;
  logic [DATA_W:0]       wd_d;
  logic [IMM_W-1:0]      imm_d;
  logic                  rd_en_d, we_d, src1_d, src2_d;
  logic [2:0]            op_d;

  // rst gates the handshake and the write strobe so nothing leaks out in
  // the cycle where reset is being applied.
  assign cmd_ready  = !rst && (state == ST_IDLE || (state == ST_DONE && resp_ready));
  assign accept     = cmd_valid && cmd_ready;
  assign reg_write  = reg_write_q && !rst;
  assign resp_valid = resp_valid_q && !rst;

  // Decode the word being latched this edge so the registered outputs are
  // already valid in the first DECODE cycle.
  assign instr_d = accept ? cmd_instr : instr_q;

  alu_instr_decode u_decode (
    .instr_word (instr_d),
    .fields     (f)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (cmd_valid) next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WB;
      ST_WB:     next_state = ST_DONE;
      ST_DONE:   if (resp_ready) next_state = cmd_valid ? ST_DECODE : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ra1_d   = '0;
    ra2_d   = '0;
    wa_d    = '0;
    wd_d    = '0;
    imm_d   = '0;
    rd_en_d = 1'b0;
    we_d    = 1'b0;
    src1_d  = 1'b0;
    src2_d  = 1'b0;
    op_d    = '0;
    if (next_state inside {ST_DECODE, ST_EXEC, ST_WB}) begin
      ra1_d   = f.rs;
      ra2_d   = f.rt;
      imm_d   = f.imm;
      rd_en_d = 1'b1;
      src1_d  = f.zero_a;
      src2_d  = f.use_imm;
      op_d    = f.alu_op;
    end
    if (next_state == ST_WB) begin
      wa_d = f.rd;
      wd_d = {ovf, alu_result};
      we_d = f.wb_en && !(R0_READ_ONLY && f.rd == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      instr_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_result  <= '0;
      resp_ovf     <= 1'b0;
      resp_zero    <= 1'b0;
      retired      <= '0;
      read_addr1   <= '0;
      read_addr2   <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      reg_read     <= 1'b0;
      reg_write_q  <= 1'b0;
      instr        <= '0;
      ALUSrc1      <= 1'b0;
      ALUSrc2      <= 1'b0;
      ALUOp        <= '0;
    end else begin
      state        <= next_state;
      instr_q      <= instr_d;
      resp_valid_q <= (next_state == ST_DONE);
      if (state == ST_EXEC) begin
        resp_result <= alu_result;
        resp_ovf    <= ovf;
        resp_zero   <= zero;
      end
      if (state == ST_DONE && resp_ready) retired <= retired + CNT_W'(1);
      read_addr1  <= ra1_d;
      read_addr2  <= ra2_d;
      write_addr  <= wa_d;
      write_data  <= wd_d;
      reg_read    <= rd_en_d;
      reg_write_q <= we_d;
      instr       <= imm_d;
      ALUSrc1     <= src1_d;
      ALUSrc2     <= src2_d;
      ALUOp       <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed table, hand-written
// backpressure/reset/wrap sequences, and randomized instructions.
module tb_alu_seq_ctrl;

  localparam int CW = 4;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [31:0]   cmd_instr;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_result;
  logic          resp_ovf, resp_zero;
  logic [CW-1:0] retired;
  logic [4:0]    read_addr1, read_addr2, write_addr;
  logic [32:0]   write_data;
  logic          reg_read, reg_write;
  logic [15:0]   instr;
  logic          ALUSrc1, ALUSrc2;
  logic [2:0]    ALUOp;
  logic [31:0]   alu_result;
  logic          ovf, zero;

  alu_seq_ctrl #(.R0_READ_ONLY(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_zero(resp_zero),
    .retired(retired),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .write_addr(write_addr),
    .write_data(write_data), .reg_read(reg_read), .reg_write(reg_write),
    .instr(instr), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp),
    .alu_result(alu_result), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic [31:0] res;
    logic        o;
    logic        z;
    logic [4:0]  e_ra1;
    logic [4:0]  e_ra2;
    logic [4:0]  e_wa;
    logic        e_we;
  } vec_t;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  logic [CW-1:0] exp_ret;
  bit            in_done;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic ui, input logic za,
                                     input logic wb, input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [15:0] imm);
    return {op, ui, za, wb, rd, rs, imm};
  endfunction

  function automatic vec_t model(input logic [31:0] ins, input logic [31:0] res,
                                 input logic o, input logic z);
    vec_t v;
    v.ins   = ins;
    v.res   = res;
    v.o     = o;
    v.z     = z;
    v.e_ra1 = ins[20:16];
    v.e_ra2 = ins[4:0];
    v.e_wa  = ins[25:21];
    v.e_we  = ins[26] && (ins[25:21] != 5'd0);
    return v;
  endfunction

  task automatic junk();
    alu_result = $urandom;
    ovf        = 1'($urandom_range(0, 1));
    zero       = 1'($urandom_range(0, 1));
  endtask

  task automatic check_idle_outputs(input string ph, input logic exp_cr);
    chk({ph, "_cmd_ready"}, cmd_ready, exp_cr);
    chk({ph, "_resp_valid"}, resp_valid, 0);
    chk({ph, "_resp_result"}, resp_result, 0);
    chk({ph, "_resp_ovf"}, resp_ovf, 0);
    chk({ph, "_resp_zero"}, resp_zero, 0);
    chk({ph, "_retired"}, retired, 0);
    chk({ph, "_ra1"}, read_addr1, 0);
    chk({ph, "_ra2"}, read_addr2, 0);
    chk({ph, "_wa"}, write_addr, 0);
    chk({ph, "_wd"}, write_data, 0);
    chk({ph, "_reg_read"}, reg_read, 0);
    chk({ph, "_reg_write"}, reg_write, 0);
    chk({ph, "_instr"}, instr, 0);
    chk({ph, "_src1"}, ALUSrc1, 0);
    chk({ph, "_src2"}, ALUSrc2, 0);
    chk({ph, "_aluop"}, ALUOp, 0);
  endtask

  task automatic check_ctrl(input string ph, input vec_t v);
    chk({ph, "_ra1"}, read_addr1, v.e_ra1);
    chk({ph, "_ra2"}, read_addr2, v.e_ra2);
    chk({ph, "_reg_read"}, reg_read, 1);
    chk({ph, "_instr"}, instr, v.ins[15:0]);
    chk({ph, "_src1"}, ALUSrc1, v.ins[27]);
    chk({ph, "_src2"}, ALUSrc2, v.ins[28]);
    chk({ph, "_aluop"}, ALUOp, v.ins[31:29]);
    chk({ph, "_resp_valid"}, resp_valid, 0);
    chk({ph, "_cmd_ready"}, cmd_ready, 0);
  endtask

  task automatic check_done(input string ph, input vec_t v);
    chk({ph, "_resp_valid"}, resp_valid, 1);
    chk({ph, "_resp_result"}, resp_result, v.res);
    chk({ph, "_resp_ovf"}, resp_ovf, v.o);
    chk({ph, "_resp_zero"}, resp_zero, v.z);
    chk({ph, "_reg_write"}, reg_write, 0);
    chk({ph, "_reg_read"}, reg_read, 0);
    chk({ph, "_ra1"}, read_addr1, 0);
    chk({ph, "_ra2"}, read_addr2, 0);
    chk({ph, "_wa"}, write_addr, 0);
    chk({ph, "_instr"}, instr, 0);
    chk({ph, "_src"}, {ALUSrc1, ALUSrc2, ALUOp}, 0);
    chk({ph, "_cmd_ready"}, cmd_ready, 0);
    chk({ph, "_retired"}, retired, exp_ret);
  endtask

  // Issues one instruction and follows it through to the response.
  // Entered around a negedge with the DUT in IDLE, or in DONE with
  // resp_ready already raised (back-to-back issue). With chain=1 it returns
  // in DONE with resp_ready=1 so the next call issues in the same cycle.
  task automatic run(input vec_t v, input int hold, input bit chain);
    cmd_valid  = 1'b1;
    cmd_instr  = v.ins;
    resp_ready = 1'b1;
    #1;
    chk("accept_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    if (in_done) exp_ret = exp_ret + 1'b1;
    in_done = 1'b0;
    #1;
    cmd_valid  = 1'b0;
    cmd_instr  = $urandom;
    resp_ready = 1'b0;
    junk();
    @(negedge clk);
    check_ctrl("dec", v);
    chk("dec_reg_write", reg_write, 0);
    chk("dec_retired", retired, exp_ret);
    @(posedge clk);
    #1;
    alu_result = v.res;
    ovf        = v.o;
    zero       = v.z;
    @(negedge clk);
    check_ctrl("exec", v);
    chk("exec_reg_write", reg_write, 0);
    @(posedge clk);
    #1;
    junk();
    cmd_valid = 1'b1;
    cmd_instr = $urandom;
    @(negedge clk);
    check_ctrl("wb", v);
    chk("wb_write_addr", write_addr, v.e_wa);
    chk("wb_write_data", write_data, {v.o, v.res});
    chk("wb_reg_write", reg_write, v.e_we);
    @(posedge clk);
    #1;
    junk();
    @(negedge clk);
    check_done("done", v);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      junk();
      cmd_instr = $urandom;
      @(negedge clk);
      check_done("hold", v);
    end
    resp_ready = 1'b1;
    cmd_valid  = 1'b0;
    if (chain) begin
      in_done = 1'b1;
    end else begin
      #1;
      chk("release_cmd_ready", cmd_ready, 1);
      @(posedge clk);
      exp_ret = exp_ret + 1'b1;
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk("after_resp_valid", resp_valid, 0);
      chk("after_cmd_ready", cmd_ready, 1);
      chk("after_retired", retired, exp_ret);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst", 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    exp_ret = '0;
    in_done = 1'b0;
  endtask

  vec_t tbl[5];
  vec_t v;

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_instr  = '0;
    resp_ready = 1'b0;
    alu_result = '0;
    ovf        = 1'b0;
    zero       = 1'b0;
    exp_ret    = '0;
    in_done    = 1'b0;

    //          ins                                                res           o     z     ra1    ra2     wa     we
    tbl[0] = '{mk(3'b010, 0, 0, 1, 5'd7, 5'd3, 16'h0005),  32'h0000_0010, 1'b0, 1'b0, 5'd3,  5'd5,  5'd7,  1'b1};
    tbl[1] = '{mk(3'b101, 1, 1, 1, 5'd2, 5'd9, 16'hFFFF),  32'h8000_0000, 1'b1, 1'b0, 5'd9,  5'h1F, 5'd2,  1'b1};
    tbl[2] = '{mk(3'b110, 0, 0, 1, 5'd0, 5'd4, 16'h0001),  32'h0000_0000, 1'b0, 1'b1, 5'd4,  5'd1,  5'd0,  1'b0};
    tbl[3] = '{mk(3'b001, 0, 1, 0, 5'd5, 5'd31, 16'hA5C6), 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd31, 5'd6,  5'd5,  1'b0};
    tbl[4] = '{mk(3'b111, 1, 0, 1, 5'd31, 5'd0, 16'h7FE0), 32'h1234_5678, 1'b0, 1'b0, 5'd0,  5'd0,  5'd31, 1'b1};

    do_reset();

    foreach (tbl[i]) run(tbl[i], 0, 1'b0);

    // Backpressure for 6 cycles, then back-to-back issue from DONE.
    run(model(mk(3'b011, 0, 0, 1, 5'd12, 5'd8, 16'h000A), 32'h0000_00FF, 1'b0, 1'b0), 6, 1'b1);
    run(model(mk(3'b100, 1, 0, 1, 5'd13, 5'd1, 16'h0042), 32'hFFFF_FFFF, 1'b1, 1'b0), 0, 1'b0);

    for (int i = 0; i < 20; i++)
      run(model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
          int'($urandom_range(0, 3)), (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0);

    // Reset while the write-back cycle is on the datapath.
    chk("pre_midrst_retired_nonzero", (retired != 0), 1);
    cmd_valid = 1'b1;
    cmd_instr = mk(3'b001, 0, 0, 1, 5'd7, 5'd3, 16'h0005);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_reg_write", reg_write, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst_after", 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
      chk("midrst_no_write", reg_write, 0);
    end
    exp_ret = '0;
    in_done = 1'b0;

    // 17 retirements on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++)
      run(model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
          0, (i < 16) ? 1'($urandom_range(0, 1)) : 1'b0);
    chk("wrap_retired", retired, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control sequencer that drives the ALU/register-file datapath (alu_regfile) from the issue side.
- Accepts a 32-bit micro-instruction over a valid/ready handshake and sequences the datapath through DECODE, EXEC and WB.
- Drives the read/write addresses, ALUSrc1/ALUSrc2, ALUOp, reg_read and reg_write; captures alu_result, ovf and zero.
- Returns a status response over a second valid/ready handshake and counts retired instructions.

Parameters:
- R0_READ_ONLY, 1: when 1, write-back to register 0 is suppressed.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  instruction valid
- cmd_ready  out  1  sequencer can accept an instruction
- cmd_instr  in  32  micro-instruction: [31:29] alu_op, [28] use_imm, [27] zero_a, [26] wb_en, [25:21] rd, [20:16] rs, [15:0] imm (rt = imm[4:0] when use_imm=0)
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_result  out  32  captured ALU result
- resp_ovf  out  1  captured overflow flag
- resp_zero  out  1  captured zero flag
- retired  out  CNT_W  count of completed responses
- read_addr1  out  5  to datapath
- read_addr2  out  5  to datapath
- write_addr  out  5  to datapath
- write_data  out  33  to datapath
- reg_read  out  1  to datapath
- reg_write  out  1  to datapath
- instr  out  16  immediate to datapath
- ALUSrc1  out  1  to datapath
- ALUSrc2  out  1  to datapath
- ALUOp  out  3  to datapath
- alu_result  in  32  from datapath
- ovf  in  1  from datapath
- zero  in  1  from datapath

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE; every output 0, including cmd_ready. cmd_ready rises the first cycle after rst deasserts.
- States: IDLE, DECODE, EXEC, WB, DONE. All datapath-facing outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_instr and go to DECODE.
- DECODE:
  - read_addr1=rs, read_addr2=imm[4:0], reg_read=1.
  - instr=imm, ALUSrc1=zero_a, ALUSrc2=use_imm, ALUOp=alu_op.
  - Go to EXEC.
- EXEC:
  - All DECODE outputs held.
  - At the end of the cycle, capture alu_result, ovf and zero into resp_* holding registers.
  - Go to WB.
- WB:
  - Address and ALU controls held.
  - write_addr=rd, write_data={captured ovf, captured result}.
  - reg_write=1 for exactly this cycle if wb_en=1 and not (R0_READ_ONLY=1 and rd=0).
  - Go to DONE.
- DONE:
  - resp_valid=1; resp_* stable until the handshake completes.
  - reg_read, reg_write, ALUSrc1, ALUSrc2, ALUOp, read/write addresses and instr return to 0.
  - On resp_ready, retired increments (wraps modulo 2^CNT_W).
- cmd_ready = IDLE, or (DONE and resp_ready).
  - DONE with resp_ready and cmd_valid: accept the new instruction in that cycle and go directly to DECODE (back-to-back issue).
  - DONE with resp_ready and no cmd_valid: go to IDLE.
- Latency: handshake in cycle N → DECODE N+1, EXEC N+2, WB N+3, resp_valid N+4. Back-to-back throughput is one instruction per 4 cycles.
- resp_ready held low: remain in DONE indefinitely; response stable; no new command accepted.
- cmd_valid while not ready: ignored; the instruction is not latched.
- Reset mid-operation: abort immediately. reg_write is 0 in the reset cycle, no partial write occurs, retired clears to 0, and no response is produced.
- Reserved instruction bits: imm[15:5] is used only as the immediate; nothing else is ignored.

Decomposition:
- Shared package (alu_ctrl_pkg) holds:
  - state encoding constants ST_IDLE..ST_DONE;
  - field positions and widths for the micro-instruction (OP_MSB, RD_LSB, etc.);
  - REG_ADDR_W=5 and DATA_W=32.
- One sub-module: alu_instr_decode, a combinational field split of the latched instruction into rd, rs, rt, imm and the control bits. The FSM stays in the top module.

Test Plan:
- Single op: after reset, send instr rs=3, rt=5, alu_op=3'b010, use_imm=0, wb_en=1, rd=7; bench ALU drives alu_result=0x0000_0010, ovf=0, zero=0 in EXEC → read_addr1=3, read_addr2=5 in N+1..N+3; one-cycle reg_write at N+3 with write_addr=7, write_data=33'h0_0000_0010; resp_valid at N+4; retired=1.
- Immediate/zero_a: use_imm=1, zero_a=1, imm=0xFFFF, wb_en=1, rd=2 → ALUSrc1=1, ALUSrc2=1, instr=0xFFFF during DECODE..WB; ovf=1 from the bench gives write_data bit32=1 and resp_ovf=1.
- R0 protect: wb_en=1, rd=0, R0_READ_ONLY=1 → reg_write never asserts; response still produced; retired increments.
- Backpressure / back-to-back: hold resp_ready=0 for 6 cycles → resp_* stable and cmd_ready=0. Then assert resp_ready with cmd_valid high → same-cycle accept, DECODE next cycle; two responses; retired=2.
- Reset mid-op: assert rst during WB → reg_write=0 that cycle, all outputs 0, retired=0, no resp_valid; cmd_ready=1 the cycle after rst falls.
- Counter wrap: CNT_W=4, 17 instructions → retired=1.
